muldiv_iter: RTL and testbench



---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/muldiv_iter_step.sv | 38 +++
 rtl/muldiv_iter.sv | 183 ++++++++++++++++++
 tb/tb_muldiv_iter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MULTU = 3'b000,
    MD_MULT  = 3'b001,
    MD_DIVU  = 3'b010,
    MD_DIV   = 3'b011,
    MD_MADDU = 3'b100,
    MD_MADD  = 3'b101,
    MD_MSUBU = 3'b110,
    MD_MSUB  = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PREP = 2'b01,
    ST_ITER = 2'b10,
    ST_FIX  = 2'b11
  } md_state_e;

  function automatic logic is_div(input md_op_e op);
    return (op == MD_DIVU) || (op == MD_DIV);
  endfunction

  function automatic logic is_signed(input md_op_e op);
    return op[0];
  endfunction

  function automatic logic is_acc(input md_op_e op);
    return op[2];
  endfunction

  function automatic logic is_sub(input md_op_e op);
    return (op == MD_MSUBU) || (op == MD_MSUB);
  endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One iteration of the datapath: STEP shift-add (multiply) or restoring-subtract
// (divide) steps on the 2*WIDTH partial register {hi_part, lo_part}.
module muldiv_iter_step #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic                 div_mode,
  input  logic [2*WIDTH-1:0]   part_i,
  input  logic [WIDTH-1:0]     opnd_i,
  output logic [2*WIDTH-1:0]   part_o
);

  logic [2*WIDTH-1:0] p;
  logic [WIDTH:0]     t;

  always_comb begin
    p = part_i;
    t = '0;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (div_mode) begin
        // Shift remainder:quotient left, subtract divisor if it fits, retire quotient bit.
        t = p[2*WIDTH-1:WIDTH-1];
        if (t >= {1'b0, opnd_i}) begin
          t = t - {1'b0, opnd_i};
          p = {t[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
        end else begin
          p = {t[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
        end
      end else begin
        // Add multiplicand into the upper half when the multiplier LSB is set, then shift right.
        t = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
        p = {t, p[WIDTH-1:1]};
      end
    end
    part_o = p;
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide/multiply-accumulate unit writing architectural HI/LO,
// with start/busy/done handshake and direct HI/LO write that aborts any op in flight.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             we,
  input  logic             hilo,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned N     = WIDTH / STEP;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int unsigned PW    = 2 * WIDTH;

  md_state_e        state_q, state_d;
  md_op_e           op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, opnd_q, opnd_d;
  logic [PW-1:0]    part_q, part_d, snap_q, snap_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, quot, rem, q_res, r_res;
  logic [PW-1:0]    prod, acc_res, step_part;

  // Operand magnitudes and sign-corrected results
  assign a_neg   = is_signed(op_q) & a_q[WIDTH-1];
  assign b_neg   = is_signed(op_q) & b_q[WIDTH-1];
  assign a_mag   = a_neg ? (~a_q + WIDTH'(1)) : a_q;
  assign b_mag   = b_neg ? (~b_q + WIDTH'(1)) : b_q;
  assign prod    = qneg_q ? (~part_q + PW'(1)) : part_q;
  assign quot    = part_q[WIDTH-1:0];
  assign rem     = part_q[PW-1:WIDTH];
  assign q_res   = qneg_q ? (~quot + WIDTH'(1)) : quot;
  assign r_res   = rneg_q ? (~rem + WIDTH'(1)) : rem;
  assign acc_res = is_sub(op_q) ? (snap_q - prod) : (snap_q + prod);

  muldiv_iter_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .div_mode (is_div(op_q)),
    .part_i   (part_q),
    .opnd_i   (opnd_q),
    .part_o   (step_part)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    opnd_d  = opnd_q;
    part_d  = part_q;
    snap_d  = snap_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;

    if (we) begin
      // Direct write wins over everything and abandons any op in flight.
      if (hilo) hi_d = a;
      else      lo_d = a;
      state_d = ST_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_PREP;
            op_d    = md_op_e'(op);
            a_d     = a;
            b_d     = b;
            dz_d    = 1'b0;
            busy_d  = 1'b1;
          end
        end
        ST_PREP: begin
          state_d = ST_ITER;
          cnt_d   = CNT_W'(N);
          snap_d  = {hi_q, lo_q};
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          if (is_div(op_q)) begin
            part_d = {{WIDTH{1'b0}}, a_mag};
            opnd_d = b_mag;
          end else begin
            part_d = {{WIDTH{1'b0}}, b_mag};
            opnd_d = a_mag;
          end
        end
        ST_ITER: begin
          part_d = step_part;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
        end
        ST_FIX: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (is_div(op_q)) begin
            if (b_q == '0) begin
              lo_d = '1;
              hi_d = a_q;
              dz_d = 1'b1;
            end else begin
              lo_d = q_res;
              hi_d = r_res;
            end
          end else if (is_acc(op_q)) begin
            {hi_d, lo_d} = acc_res;
          end else begin
            {hi_d, lo_d} = prod;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= MD_MULTU;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      opnd_q  <= '0;
      part_q  <= '0;
      snap_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      opnd_q  <= opnd_d;
      part_q  <= part_d;
      snap_q  <= snap_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dz   = dz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed-vector bench for muldiv_iter: a 32-bit/STEP=1 instance and a 16-bit/STEP=4 instance.
module tb_muldiv_iter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] a_s, b_s;
  logic [2:0]  op_s;
  logic        we_s, hilo_s, start32, start16;

  logic        busy32, done32, dz32;
  logic [31:0] hi32, lo32;
  logic        busy16, done16, dz16;
  logic [15:0] hi16, lo16;

  logic        sel;
  logic        busy_m, done_m, dz_m;
  logic [31:0] hi_m, lo_m;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_iter #(.WIDTH(32), .STEP(1)) dut32 (
    .clk(clk), .reset_n(reset_n), .a(a_s), .b(b_s), .start(start32), .op(op_s),
    .we(we_s), .hilo(hilo_s), .busy(busy32), .done(done32), .dz(dz32),
    .hi(hi32), .lo(lo32)
  );

  muldiv_iter #(.WIDTH(16), .STEP(4)) dut16 (
    .clk(clk), .reset_n(reset_n), .a(a_s[15:0]), .b(b_s[15:0]), .start(start16), .op(op_s),
    .we(1'b0), .hilo(1'b0), .busy(busy16), .done(done16), .dz(dz16),
    .hi(hi16), .lo(lo16)
  );

  assign busy_m = sel ? busy16 : busy32;
  assign done_m = sel ? done16 : done32;
  assign dz_m   = sel ? dz16 : dz32;
  assign hi_m   = sel ? {16'h0, hi16} : hi32;
  assign lo_m   = sel ? {16'h0, lo16} : lo32;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Launch from a negedge, wait for done; returns at the negedge of the done cycle.
  // poke >= 0 re-asserts start (with other operands) at that cycle of the op.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz, input int lat, input int poke);
    int cnt;
    int bcy;
    op_s = o;
    a_s  = av;
    b_s  = bv;
    if (sel) start16 = 1'b1; else start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    start16 = 1'b0;
    cnt = 0;
    bcy = 0;
    check({tag, "_dzclr"}, 64'(dz_m), 64'(0));
    while (!done_m && cnt < 200) begin
      if (busy_m) bcy++;
      if (cnt == poke) begin
        if (sel) start16 = 1'b1; else start32 = 1'b1;
        op_s = 3'b010;
        a_s  = 32'h1;
        b_s  = 32'h1;
      end else begin
        start32 = 1'b0;
        start16 = 1'b0;
      end
      @(negedge clk);
      cnt++;
    end
    start32 = 1'b0;
    start16 = 1'b0;
    check({tag, "_lat"}, 64'(cnt), 64'(lat));
    check({tag, "_busycyc"}, 64'(bcy), 64'(lat));
    check({tag, "_busy_in_done"}, 64'(busy_m), 64'(0));
    check({tag, "_hi"}, 64'(hi_m), 64'(ehi));
    check({tag, "_lo"}, 64'(lo_m), 64'(elo));
    check({tag, "_dz"}, 64'(dz_m), 64'(edz));
  endtask

  initial begin
    int saw;
    reset_n = 1'b0;
    a_s = '0; b_s = '0; op_s = '0; we_s = 1'b0; hilo_s = 1'b0;
    start32 = 1'b0; start16 = 1'b0; sel = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hi", 64'(hi32), 64'(0));
    check("rst_lo", 64'(lo32), 64'(0));
    check("rst_busy", 64'(busy32), 64'(0));
    check("rst_done", 64'(done32), 64'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // Back-to-back chain: each op launched in the previous op's done cycle.
    run_op("multu_max", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34, -1);
    run_op("mult_neg", 3'b001, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 34, -1);
    run_op("div_neg", 3'b011, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, -1);
    run_op("div_minm1", 3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 34, -1);
    run_op("divu_zero", 3'b010, 32'hA, 32'h0, 32'h0000000A, 32'hFFFFFFFF, 1'b1, 34, -1);

    // Preset HI/LO via direct writes
    we_s = 1'b1; hilo_s = 1'b1; a_s = 32'h0;
    @(negedge clk);
    hilo_s = 1'b0; a_s = 32'h5;
    @(negedge clk);
    we_s = 1'b0;
    check("we_hi", 64'(hi32), 64'(0));
    check("we_lo", 64'(lo32), 64'(5));
    check("we_dz_kept", 64'(dz32), 64'(1));
    run_op("madd", 3'b101, 32'h2, 32'h3, 32'h0, 32'h0000000B, 1'b0, 34, -1);
    run_op("msubu", 3'b110, 32'h1, 32'h10, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0, 34, -1);

    // start ignored while busy: result comes from the first op only
    @(negedge clk);
    run_op("start_busy", 3'b000, 32'h7, 32'h9, 32'h0, 32'd63, 1'b0, 34, 3);

    // start together with we: only the write happens
    @(negedge clk);
    we_s = 1'b1; start32 = 1'b1; hilo_s = 1'b1; a_s = 32'h55; op_s = 3'b000;
    @(negedge clk);
    we_s = 1'b0; start32 = 1'b0;
    check("wes_hi", 64'(hi32), 64'(32'h55));
    check("wes_busy", 64'(busy32), 64'(0));
    @(negedge clk);
    check("wes_busy2", 64'(busy32), 64'(0));

    // Abort a divu mid-iteration with a LO write
    op_s = 3'b010; a_s = 32'd100; b_s = 32'd7; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_busy_pre", 64'(busy32), 64'(1));
    we_s = 1'b1; hilo_s = 1'b0; a_s = 32'h1234;
    @(negedge clk);
    we_s = 1'b0;
    check("abort_busy", 64'(busy32), 64'(0));
    check("abort_lo", 64'(lo32), 64'(32'h1234));
    check("abort_hi", 64'(hi32), 64'(32'h55));
    saw = 0;
    repeat (40) begin
      if (done32) saw = 1;
      @(negedge clk);
    end
    check("abort_nodone", 64'(saw), 64'(0));
    check("abort_lo_after", 64'(lo32), 64'(32'h1234));

    // Asynchronous reset in the middle of ITER
    op_s = 3'b000; a_s = 32'h3; b_s = 32'h3; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("arst_hi", 64'(hi32), 64'(0));
    check("arst_lo", 64'(lo32), 64'(0));
    check("arst_busy", 64'(busy32), 64'(0));
    check("arst_done", 64'(done32), 64'(0));
    check("arst_dz", 64'(dz32), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // WIDTH=16, STEP=4 instance: latency N+2 = 6
    sel = 1'b1;
    run_op("w16_multu", 3'b000, 32'hFFFF, 32'hFFFF, 32'hFFFE, 32'h0001, 1'b0, 6, -1);
    run_op("w16_div", 3'b011, 32'hFFF9, 32'h2, 32'hFFFF, 32'hFFFD, 1'b0, 6, -1);
    run_op("w16_divu0", 3'b010, 32'h5, 32'h0, 32'h5, 32'hFFFF, 1'b1, 6, -1);
    run_op("w16_madd", 3'b101, 32'hFFFD, 32'h4, 32'h0005, 32'hFFF3, 1'b0, 6, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
